// File: rtl/dmem_pkg.sv
// Shared types and access-size helpers for the data-memory controller.
// Build option DMEM_BYTE_WE_EN selects byte-enable SRAM writes instead of read-modify-write.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_RD  = 2'd2,
    RMW_WR  = 2'd3
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved encodings (011/110/111) fall through to the word case.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: lane_mask = 4'b0001 << offset;
      F3_H, F3_HU: lane_mask = 4'b0011 << {offset[1], 1'b0};
      default:     lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = offset[0];
      default:     misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// LSU-side request/response and SRAM-side signals of the data-memory controller.
// mem_be exists only when DMEM_BYTE_WE_EN is defined.
interface dmem_ctrl_if #(parameter int ADDR_W = 10);
  logic              MemReqM;
  logic              MemWriteM;
  logic [2:0]        funct3M;
  logic [31:0]       AddrM;
  logic [31:0]       StoreDataM;
  logic [31:0]       ReadDataM;
  logic              StallM;
  logic              DoneM;
  logic              MisalignM;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef DMEM_BYTE_WE_EN
  logic [3:0]        mem_be;

  modport slave (
    input  MemReqM, MemWriteM, funct3M, AddrM, StoreDataM, mem_rdata,
    output ReadDataM, StallM, DoneM, MisalignM, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output MemReqM, MemWriteM, funct3M, AddrM, StoreDataM, mem_rdata,
    input  ReadDataM, StallM, DoneM, MisalignM, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
`else
  modport slave (
    input  MemReqM, MemWriteM, funct3M, AddrM, StoreDataM, mem_rdata,
    output ReadDataM, StallM, DoneM, MisalignM, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output MemReqM, MemWriteM, funct3M, AddrM, StoreDataM, mem_rdata,
    input  ReadDataM, StallM, DoneM, MisalignM, mem_en, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/dmem_byte_merge.sv
// Replicates store data into every lane of its size and splices the enabled lanes over old_word.
// Purely combinational; with be=1111 the output is the plain lane replication.
module byte_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic [3:0]  be,
  output logic [31:0] merged_word
);

  logic [31:0] repl;

  always_comb begin
    case (funct3)
      F3_B, F3_BU: repl = {4{store_data[7:0]}};
      F3_H, F3_HU: repl = {2{store_data[15:0]}};
      default:     repl = store_data;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = be[i] ? repl[8*i +: 8] : old_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: 2-cycle loads, 1-cycle sw, 3-cycle sb/sh read-modify-write.
// Defining DMEM_BYTE_WE_EN makes sb/sh single-cycle byte-enable writes and drops the RMW states.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  dmem_ctrl_if.slave bus
);

  dmem_state_t state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [3:0]  merge_be;
  logic        mis;
  logic [31:0] rot;
  logic [31:0] merged;

  logic        stall, done, misal, en, we;
  logic [31:0] rdata, wdata;

  assign off  = bus.AddrM[1:0];
  assign mask = lane_mask(bus.funct3M, off);
  assign mis  = misaligned(bus.funct3M, off);

  always_comb begin
    case (off)
      2'd0:    rot = bus.mem_rdata;
      2'd1:    rot = {bus.mem_rdata[7:0],  bus.mem_rdata[31:8]};
      2'd2:    rot = {bus.mem_rdata[15:0], bus.mem_rdata[31:16]};
      default: rot = {bus.mem_rdata[23:0], bus.mem_rdata[31:24]};
    endcase
  end

`ifdef DMEM_BYTE_WE_EN
  assign merge_be = 4'b1111;
  logic [3:0] be;
`else
  assign merge_be = mask;
  logic [31:0] merge_q, merge_d;
`endif

  byte_merge u_merge (
    .old_word    (bus.mem_rdata),
    .store_data  (bus.StoreDataM),
    .funct3      (bus.funct3M),
    .be          (merge_be),
    .merged_word (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
`ifndef DMEM_BYTE_WE_EN
      merge_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
`ifndef DMEM_BYTE_WE_EN
      merge_q <= merge_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rdata   = hold_q;
    stall   = 1'b0;
    done    = 1'b0;
    misal   = 1'b0;
    en      = 1'b0;
    we      = 1'b0;
    wdata   = '0;
`ifdef DMEM_BYTE_WE_EN
    be      = 4'b0000;
`else
    merge_d = merge_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.MemReqM) begin
          if (mis) begin
            misal = 1'b1;
            done  = 1'b1;
          end else if (!bus.MemWriteM) begin
            en      = 1'b1;
            stall   = 1'b1;
            state_d = LD_WAIT;
          end else if (mask == 4'b1111) begin
            en    = 1'b1;
            we    = 1'b1;
            wdata = bus.StoreDataM;
            done  = 1'b1;
`ifdef DMEM_BYTE_WE_EN
            be    = 4'b1111;
`endif
          end else begin
`ifdef DMEM_BYTE_WE_EN
            en    = 1'b1;
            we    = 1'b1;
            wdata = merged;
            be    = mask;
            done  = 1'b1;
`else
            // Sub-word store: fetch the old word first, write it back merged.
            en      = 1'b1;
            stall   = 1'b1;
            state_d = RMW_RD;
`endif
          end
        end
      end
      LD_WAIT: begin
        rdata   = rot;
        hold_d  = rot;
        done    = 1'b1;
        state_d = IDLE;
      end
`ifndef DMEM_BYTE_WE_EN
      RMW_RD: begin
        merge_d = merged;
        stall   = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        en      = 1'b1;
        we      = 1'b1;
        wdata   = merge_q;
        done    = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low during reset so an in-flight RMW write never reaches the SRAM.
  assign bus.ReadDataM = reset ? 32'd0 : rdata;
  assign bus.StallM    = stall & ~reset;
  assign bus.DoneM     = done  & ~reset;
  assign bus.MisalignM = misal & ~reset;
  assign bus.mem_en    = en    & ~reset;
  assign bus.mem_we    = we    & ~reset;
  assign bus.mem_wdata = reset ? 32'd0 : wdata;
  assign bus.mem_addr  = reset ? '0 : bus.AddrM[ADDR_W+1:2];
`ifdef DMEM_BYTE_WE_EN
  assign bus.mem_be    = reset ? 4'b0000 : be;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases followed by random loads/stores
// checked against a byte-level memory model and access-latency rules.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(10)) bus ();

  dmem_ctrl #(.ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM with 1-cycle read latency; presets are applied by this process only.
  logic [31:0] sram [1024];
  logic        pre_vld;
  logic [9:0]  pre_idx;
  logic [31:0] pre_dat;

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (pre_vld) sram[pre_idx] = pre_dat;
    if (bus.mem_en) begin
      if (bus.mem_we) begin
`ifdef DMEM_BYTE_WE_EN
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
`else
        sram[bus.mem_addr] = bus.mem_wdata;
`endif
      end else begin
        bus.mem_rdata <= sram[bus.mem_addr];
      end
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [4096];
  logic [31:0] last_load;
  int n_cmp = 0;
  int n_err = 0;

  int          r_stalls;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [11:0] base;
    base = {addr[11:2], 2'b00};
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic preset(input logic [31:0] addr, input logic [31:0] val);
    @(posedge clk); #1;
    pre_vld = 1'b1; pre_idx = addr[11:2]; pre_dat = val;
    @(posedge clk); #1;
    pre_vld = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[{addr[11:2], 2'b00} + 12'(k)] = val[8*k +: 8];
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    bus.MemReqM = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, bus.StallM}, 32'd0);
    chk("idle_hold", bus.ReadDataM, last_load);
  endtask

  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd);
    int          size, exp_stalls;
    logic        exp_mis, done_seen, saw_en, mis, stall_at_done;
    logic [31:0] exp_rd, w;
    logic [63:0] ww;
    logic [3:0]  exp_be;
    @(posedge clk); #1;
    bus.MemReqM = 1'b1; bus.MemWriteM = wr; bus.funct3M = f3;
    bus.AddrM = addr; bus.StoreDataM = sd;
    size    = f3[1] ? 4 : (f3[0] ? 2 : 1);
    exp_mis = (int'(addr[1:0]) % size) != 0;
    w       = ref_word(addr);
    ww      = {w, w} >> (8 * int'(addr[1:0]));
    exp_rd  = ww[31:0];
    exp_be  = 4'((1 << size) - 1) << addr[1:0];
    if (exp_mis) exp_stalls = 0;
    else if (!wr) exp_stalls = 1;
    else if (size == 4) exp_stalls = 0;
`ifdef DMEM_BYTE_WE_EN
    else exp_stalls = 0;
`else
    else exp_stalls = 2;
`endif
    r_stalls = 0; done_seen = 1'b0; saw_en = 1'b0; mis = 1'b0; stall_at_done = 1'b0;
    r_rdata = 32'd0; r_be = 4'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_en) saw_en = 1'b1;
      if (bus.DoneM) begin
        done_seen = 1'b1; mis = bus.MisalignM; r_rdata = bus.ReadDataM;
        stall_at_done = bus.StallM;
`ifdef DMEM_BYTE_WE_EN
        r_be = bus.mem_be;
`endif
        break;
      end
      if (bus.StallM) r_stalls++;
      @(posedge clk); #1;
    end
    chk("done_seen", {31'd0, done_seen}, 32'd1);
    chk("stall_cycles", r_stalls, exp_stalls);
    chk("stall_at_done", {31'd0, stall_at_done}, 32'd0);
    chk("misalign", {31'd0, mis}, {31'd0, exp_mis});
    chk("mem_en_seen", {31'd0, saw_en}, {31'd0, !exp_mis});
    if (!exp_mis && !wr) begin
      chk("load_data", r_rdata, exp_rd);
      last_load = exp_rd;
    end
    if (!exp_mis && wr) begin
`ifdef DMEM_BYTE_WE_EN
      chk("byte_en", {28'd0, r_be}, {28'd0, exp_be});
`endif
      for (int k = 0; k < size; k++)
        ref_mem[{addr[11:2], 2'b00} + 12'(addr[1:0]) + 12'(k)] = sd[8*k +: 8];
    end
  endtask

  logic [31:0] ext;
  int          bad_words;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    last_load = 32'd0;
    pre_vld = 1'b0; pre_idx = '0; pre_dat = '0;
    reset = 1'b1;
    bus.MemReqM = 1'b1; bus.MemWriteM = 1'b0; bus.funct3M = F3_W;
    bus.AddrM = 32'h10; bus.StoreDataM = 32'hFFFF_FFFF; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_stall", {31'd0, bus.StallM}, 32'd0);
    chk("rst_done", {31'd0, bus.DoneM}, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_rdata", bus.ReadDataM, 32'd0);
    chk("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
    bus.MemReqM = 1'b0;
    preset(32'h10, 32'h1122_3344);
    preset(32'h20, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    access(1'b0, F3_W, 32'h10, 32'h0);
    chk("plan_lw", r_rdata, 32'h1122_3344);
    access(1'b0, F3_H, 32'h12, 32'h0);
    chk("plan_lh_rot", r_rdata, 32'h3344_1122);
    ext = {{16{r_rdata[15]}}, r_rdata[15:0]};
    chk("plan_lh_ext", ext, 32'h0000_1122);
    access(1'b1, F3_B, 32'h12, 32'hFFFF_FFAB);
`ifdef DMEM_BYTE_WE_EN
    chk("plan_sb_be", {28'd0, r_be}, 32'h4);
`else
    chk("plan_sb_stalls", r_stalls, 2);
`endif
    idle_check();
    chk("plan_sb_word", sram[4], 32'h11AB_3344);
    access(1'b0, F3_W, 32'h11, 32'h0);
    access(1'b1, F3_W, 32'h20, 32'h0000_CAFE);
    access(1'b0, F3_W, 32'h20, 32'h0);
    chk("plan_sw_lw", r_rdata, 32'h0000_CAFE);

`ifndef DMEM_BYTE_WE_EN
    // Reset while the RMW read is in flight must leave the SRAM untouched.
    bus.MemReqM = 1'b0;
    preset(32'h10, 32'h1122_3344);
    bus.MemReqM = 1'b1; bus.MemWriteM = 1'b1; bus.funct3M = F3_H;
    bus.AddrM = 32'h10; bus.StoreDataM = 32'h0000_5555;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rmw_rst_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rmw_rst_stall", {31'd0, bus.StallM}, 32'd0);
    chk("rmw_rst_done", {31'd0, bus.DoneM}, 32'd0);
    chk("rmw_rst_rdata", bus.ReadDataM, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.MemReqM = 1'b0;
    last_load = 32'd0;
    @(negedge clk);
    chk("rmw_rst_sram", sram[4], 32'h1122_3344);
    chk("rmw_rst_idle", {31'd0, bus.StallM}, 32'd0);
    chk("rmw_rst_hold", bus.ReadDataM, 32'd0);
`endif

    // Reset while a load waits for data discards the load.
    bus.MemReqM = 1'b1; bus.MemWriteM = 1'b0; bus.funct3M = F3_W; bus.AddrM = 32'h20;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("ld_rst_rdata", bus.ReadDataM, 32'd0);
    chk("ld_rst_done", {31'd0, bus.DoneM}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.MemReqM = 1'b0;
    last_load = 32'd0;
    idle_check();
    access(1'b0, F3_W, 32'h10, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic        wr;
      logic [2:0]  f3;
      a  = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      wr = $urandom_range(0, 1) == 1;
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) idle_check();
      access(wr, f3, a, $urandom);
    end
    idle_check();

    bad_words = 0;
    for (int i = 0; i < 1024; i++)
      if (sram[i] !== ref_word(32'(i) << 2)) bad_words++;
    chk("final_sram_words_bad", bad_words, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Multi-cycle data-memory controller in the M stage, between the load/store unit and a single-port synchronous word SRAM with 1-cycle read latency.
- Aligns load data to the byte offset for the LSU's extend logic.
- Executes sb/sh as an internal read-modify-write (RMW) and sw as a single write.
- Stalls the pipeline while an access is in flight and flags misaligned accesses.

Parameters:
- ADDR_W, 10, word-address width of the SRAM (1024 words = 4 KiB).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemReqM  in  1  M-stage load/store request; held stable while StallM=1.
- MemWriteM  in  1  1 = store, 0 = load.
- funct3M  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- AddrM  in  32  byte address; bits [ADDR_W+1:2] index the SRAM, upper bits ignored (alias).
- StoreDataM  in  32  raw rs2 store data, low-aligned.
- ReadDataM  out  32  loaded word rotated right by 8*AddrM[1:0]; feeds the LSU extend logic.
- StallM  out  1  freeze F/D/E/M stages this cycle.
- DoneM  out  1  one-cycle pulse when the access completes.
- MisalignM  out  1  one-cycle pulse on a misaligned request; no memory access is made.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable (whole word).
- mem_addr  out  ADDR_W  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after a read enable.

Behaviour:
- Reset (async): state=IDLE, hold/merge registers = 0. All outputs are 0 while reset is high, including StallM and ReadDataM.
- Misaligned request: h with AddrM[0]=1, or w with AddrM[1:0]≠0.
  - In IDLE: MisalignM=1 and DoneM=1 in the same cycle, StallM=0, mem_en=0, state stays IDLE.
- States: IDLE, LD_WAIT, RMW_RD, RMW_WR.
- IDLE, no request: mem_en=0, StallM=0.
- IDLE, load: mem_en=1, mem_we=0, StallM=1, go to LD_WAIT.
- LD_WAIT:
  - ReadDataM = rotr(mem_rdata, 8*AddrM[1:0]); latch this into the hold register.
  - DoneM=1, StallM=0, go to IDLE.
  - Load latency is 2 cycles with 1 stall cycle.
- IDLE, sw: mem_en=1, mem_we=1, mem_wdata=StoreDataM, DoneM=1, StallM=0, stay IDLE. Latency is 1 cycle.
- IDLE, sb/sh: read the target word, StallM=1, go to RMW_RD.
- RMW_RD:
  - Merge register = mem_rdata with byte lane(s) replaced by StoreDataM[7:0] or [15:0] at offset AddrM[1:0].
  - StallM=1, mem_en=0, go to RMW_WR.
- RMW_WR:
  - mem_en=1, mem_we=1, mem_wdata = merge register.
  - DoneM=1, StallM=0, go to IDLE.
  - Latency is 3 cycles with 2 stall cycles.
- ReadDataM outside LD_WAIT: the hold register (last load value).
- Back-to-back requests: a request still present in IDLE the cycle after DoneM is a new access. No idle bubble is inserted.
- funct3 011/110/111: treated as a word access (same alignment rule).
- Reset in RMW_RD or RMW_WR: the write is abandoned before the next edge (mem_en drops immediately) and SRAM is unchanged. Reset in LD_WAIT discards the load.
- mem_addr is driven from AddrM in every state; AddrM is stable because the pipeline is stalled.

Optional Feature:
- Macro: DMEM_BYTE_WE_EN.
- When defined:
  - Adds port mem_be (out, 4): per-byte write enables.
  - sb/sh write in one cycle from IDLE: mem_wdata = StoreDataM replicated into all lanes, mem_be = the lane mask, DoneM=1, StallM=0.
  - RMW_RD and RMW_WR are removed.
  - sw drives mem_be=1111.
- When undefined: the RMW flow above; no mem_be port.

Decomposition:
- Package dmem_pkg holds:
  - state enum dmem_state_t;
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - function lane_mask(funct3, offset) returning 4-bit enables;
  - function misaligned(funct3, offset).
- One sub-module, byte_merge: combinational merge of old word, store data and lane mask. It is used in the RMW path and in the DMEM_BYTE_WE_EN lane replication.

Test Plan:
- SRAM[0x10>>2] = 0x11223344; lw AddrM=0x10 → StallM high for 1 cycle, DoneM in cycle 2, ReadDataM = 0x11223344.
- lh AddrM=0x12 → ReadDataM = 0x33441122. After the LSU extend, rd = 0x00001122.
- sb AddrM=0x12, StoreDataM=0xFFFFFFAB → StallM high for 2 cycles, write in cycle 3, SRAM word = 0x11AB3344. With DMEM_BYTE_WE_EN: one cycle, mem_be=0100.
- lw AddrM=0x11 → MisalignM=1 and DoneM=1 in the same cycle, mem_en never high, StallM=0.
- sw 0x0000CAFE to 0x20 immediately followed by lw 0x20 → write in cycle 0, read issued in cycle 1, ReadDataM = 0x0000CAFE in cycle 2.
- sh AddrM=0x10, reset asserted during RMW_RD → mem_en low immediately, SRAM word stays 0x11223344, all outputs 0, state IDLE after reset release.
